// File: rtl/dining_waiter_pkg.sv
// Shared types for the dining waiter: the philosopher-visible seat view (t_state),
// the waiter's internal per-seat FSM encoding, and a width helper.
package dining_waiter_pkg;

  typedef enum logic [1:0] {
    THINKING = 2'd0,
    HUNGRY   = 2'd1,
    EATING   = 2'd2,
    READING  = 2'd3
  } t_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EAT  = 2'd2
  } seat_fsm_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/waiter_seat.sv
// One seat of the waiter: IDLE/WAIT/EAT FSM with saturating wait and eat counters,
// starvation flag and the one-cycle force_release pulse on meal timeout.
module waiter_seat
  import dining_waiter_pkg::*;
#(
  parameter int MAX_EAT      = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   req,
  input  logic   done,
  input  logic   select,
  output logic   grant,
  output logic   waiting,
  output logic   starve,
  output logic   force_release,
  output t_state seat_state
);

  localparam int WAIT_W = clog2(STARVE_LIMIT + 1);
  localparam int EAT_W  = clog2(MAX_EAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam logic [EAT_W-1:0]  EAT_MAX  = EAT_W'(MAX_EAT);

  seat_fsm_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [EAT_W-1:0]  eat_cnt_q, eat_cnt_d;
  logic              force_release_q, force_release_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      wait_cnt_q      <= '0;
      eat_cnt_q       <= '0;
      force_release_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      eat_cnt_q       <= eat_cnt_d;
      force_release_q <= force_release_d;
    end
  end

  // A release via done wins over a simultaneous timeout, so no pulse in that case.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    eat_cnt_d       = eat_cnt_q;
    force_release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (select) begin
          state_d   = EAT;
          eat_cnt_d = EAT_W'(1);
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      EAT: begin
        if (done) begin
          state_d = IDLE;
        end else if (eat_cnt_q == EAT_MAX) begin
          state_d         = IDLE;
          force_release_d = 1'b1;
        end else begin
          eat_cnt_d = eat_cnt_q + EAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    seat_state = THINKING;
    case (state_q)
      WAIT:    seat_state = HUNGRY;
      EAT:     seat_state = EATING;
      default: seat_state = THINKING;
    endcase
  end

  assign grant         = (state_q == EAT);
  assign waiting       = (state_q == WAIT);
  assign starve        = (state_q == WAIT) && (wait_cnt_q == WAIT_MAX);
  assign force_release = force_release_q;

endmodule

// File: rtl/dining_waiter.sv
// Central fork arbiter for a ring of philosophers: round-robin grants with starvation
// priority, never granting two ring-adjacent seats at once.
module dining_waiter
  import dining_waiter_pkg::*;
#(
  parameter int N_SEATS      = 8,
  parameter int MAX_EAT      = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_SEATS-1:0]          req,
  input  logic [N_SEATS-1:0]          done,
  output logic [N_SEATS-1:0]          grant,
  output logic [N_SEATS-1:0]          force_release,
  output logic [N_SEATS-1:0]          starve,
  output logic [2*N_SEATS-1:0]        seat_state,
  output logic [clog2(N_SEATS)-1:0]   rr_ptr
);

  localparam int PTR_W = clog2(N_SEATS);

  logic [N_SEATS-1:0] waiting;
  logic [N_SEATS-1:0] eligible;
  logic [N_SEATS-1:0] starve_nbr;
  logic [N_SEATS-1:0] select;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  t_state             seat_view [N_SEATS];

  function automatic logic [PTR_W-1:0] ring(input int idx);
    return PTR_W'((idx + N_SEATS) % N_SEATS);
  endfunction

  for (genvar i = 0; i < N_SEATS; i++) begin : g_seat
    waiter_seat #(
      .MAX_EAT      (MAX_EAT),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_seat (
      .clk           (clk),
      .reset         (reset),
      .req           (req[i]),
      .done          (done[i]),
      .select        (select[i]),
      .grant         (grant[i]),
      .waiting       (waiting[i]),
      .starve        (starve[i]),
      .force_release (force_release[i]),
      .seat_state    (seat_view[i])
    );

    assign seat_state[2*i +: 2] = seat_view[i];
    assign eligible[i]   = waiting[i] && req[i]
                           && !grant[(i + N_SEATS - 1) % N_SEATS]
                           && !grant[(i + 1) % N_SEATS];
    assign starve_nbr[i] = starve[(i + N_SEATS - 1) % N_SEATS] || starve[(i + 1) % N_SEATS];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Starving seats are placed first; the second pass also keeps forks free next to any starving seat.
  always_comb begin : arbitrate
    int               idx;
    logic             found1;
    logic             found2;
    logic [PTR_W-1:0] first1;
    logic [PTR_W-1:0] first2;
    idx    = 0;
    found1 = 1'b0;
    found2 = 1'b0;
    first1 = '0;
    first2 = '0;
    select = '0;
    for (int k = 0; k < N_SEATS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (eligible[ring(idx)] && starve[ring(idx)]
          && !select[ring(idx - 1)] && !select[ring(idx + 1)]) begin
        select[ring(idx)] = 1'b1;
        if (!found1) begin
          found1 = 1'b1;
          first1 = ring(idx);
        end
      end
    end
    for (int k = 0; k < N_SEATS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (eligible[ring(idx)] && !starve[ring(idx)] && !starve_nbr[ring(idx)]
          && !select[ring(idx - 1)] && !select[ring(idx + 1)]) begin
        select[ring(idx)] = 1'b1;
        if (!found2) begin
          found2 = 1'b1;
          first2 = ring(idx);
        end
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (found2) begin
      rr_ptr_d = ring(int'(first2) + 1);
    end else if (found1) begin
      rr_ptr_d = ring(int'(first1) + 1);
    end
  end

  assign rr_ptr = rr_ptr_q;

  a_no_adjacent_grants : assert property (@(posedge clk) disable iff (reset)
    (grant & {grant[0], grant[N_SEATS-1:1]}) == '0);

endmodule

// File: tb/tb_dining_waiter.sv
// Scoreboard bench for dining_waiter: directed scenarios push expected outputs per cycle,
// an independent negedge monitor pops and compares them against the DUT.
module tb_dining_waiter;

  typedef enum int {K_GRANT, K_FR, K_STARVE, K_STATE, K_RR} kind_e;

  typedef struct packed {
    int          at;
    int          tag;
    kind_e       kind;
    logic [15:0] value;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  req = 8'h00;
  logic [7:0]  done = 8'h00;
  logic [7:0]  grant;
  logic [7:0]  force_release;
  logic [7:0]  starve;
  logic [15:0] seat_state;
  logic [2:0]  rr_ptr;

  expect_t sb[$];
  int cyc = 0;
  int now_cyc = 0;
  int test_id = 0;
  int n_compared = 0;
  int n_mismatched = 0;

  dining_waiter #(
    .N_SEATS      (8),
    .MAX_EAT      (4),
    .STARVE_LIMIT (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .done          (done),
    .grant         (grant),
    .force_release (force_release),
    .starve        (starve),
    .seat_state    (seat_state),
    .rr_ptr        (rr_ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kindName(input kind_e k);
    case (k)
      K_GRANT:  return "grant";
      K_FR:     return "force_release";
      K_STARVE: return "starve";
      K_STATE:  return "seat_state";
      default:  return "rr_ptr";
    endcase
  endfunction

  function automatic logic [15:0] actualValue(input kind_e k);
    case (k)
      K_GRANT:  return {8'h00, grant};
      K_FR:     return {8'h00, force_release};
      K_STARVE: return {8'h00, starve};
      K_STATE:  return seat_state;
      default:  return {13'h0000, rr_ptr};
    endcase
  endfunction

  task automatic checkOutput(input expect_t e);
    logic [15:0] act;
    act = actualValue(e.kind);
    n_compared++;
    if (act !== e.value) begin
      n_mismatched++;
      $display("[TB] FAIL test%0d %s cycle %0d: got %h, expected %h",
               e.tag, kindName(e.kind), e.at, act, e.value);
    end
  endtask

  // Monitor: compare every scoreboard entry that falls due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d, input logic rst);
    @(negedge clk);
    req     = r;
    done    = d;
    reset   = rst;
    now_cyc = cyc;
  endtask

  task automatic expectAt(input int offset, input kind_e k, input logic [15:0] v);
    expect_t e;
    e.at    = now_cyc + offset;
    e.tag   = test_id;
    e.kind  = k;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic resetDut();
    applyStimulus(8'h00, 8'h00, 1'b1);
    expectAt(1, K_GRANT, 16'h0000);
    expectAt(1, K_FR, 16'h0000);
    expectAt(1, K_STARVE, 16'h0000);
    expectAt(1, K_STATE, 16'h0000);
    expectAt(1, K_RR, 16'h0000);
  endtask

  initial begin
    logic [7:0] r;

    // Single request on seat 3.
    test_id = 1;
    resetDut();
    applyStimulus(8'h08, 8'h00, 1'b0);
    expectAt(1, K_STATE, 16'h0040);
    expectAt(1, K_GRANT, 16'h0000);
    expectAt(2, K_GRANT, 16'h0008);
    expectAt(2, K_RR, 16'h0004);
    expectAt(3, K_GRANT, 16'h0000);
    expectAt(3, K_STATE, 16'h0000);
    applyStimulus(8'h08, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h08, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);

    // Adjacent contention on seats 2 and 3; seat 2 keeps req high through its done cycle.
    test_id = 2;
    resetDut();
    applyStimulus(8'h0C, 8'h00, 1'b0);
    expectAt(2, K_GRANT, 16'h0004);
    expectAt(2, K_RR, 16'h0003);
    expectAt(3, K_GRANT, 16'h0000);
    expectAt(4, K_GRANT, 16'h0008);
    expectAt(4, K_RR, 16'h0004);
    expectAt(4, K_STATE, 16'h0090);
    expectAt(5, K_STATE, 16'h0000);
    applyStimulus(8'h0C, 8'h00, 1'b0);
    applyStimulus(8'h0C, 8'h04, 1'b0);
    applyStimulus(8'h0C, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h08, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);

    // Ring wrap: bring rr_ptr to 7 via seat 6, then contend seats 7, 0, 1.
    test_id = 3;
    resetDut();
    applyStimulus(8'h40, 8'h00, 1'b0);
    expectAt(2, K_GRANT, 16'h0040);
    expectAt(2, K_RR, 16'h0007);
    expectAt(3, K_RR, 16'h0007);
    expectAt(4, K_STATE, 16'h4005);
    expectAt(5, K_GRANT, 16'h0082);
    expectAt(5, K_RR, 16'h0000);
    expectAt(6, K_GRANT, 16'h0000);
    applyStimulus(8'h40, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h40, 1'b0);
    applyStimulus(8'h83, 8'h00, 1'b0);
    applyStimulus(8'h83, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h82, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);

    // Timeout on seat 5, then a done on the fourth meal cycle.
    test_id = 4;
    resetDut();
    applyStimulus(8'h20, 8'h00, 1'b0);
    expectAt(2, K_GRANT, 16'h0020);
    expectAt(2, K_RR, 16'h0006);
    expectAt(5, K_GRANT, 16'h0020);
    expectAt(5, K_FR, 16'h0000);
    expectAt(6, K_GRANT, 16'h0000);
    expectAt(6, K_FR, 16'h0020);
    expectAt(7, K_FR, 16'h0000);
    expectAt(12, K_GRANT, 16'h0020);
    expectAt(13, K_GRANT, 16'h0000);
    expectAt(13, K_FR, 16'h0000);
    expectAt(14, K_FR, 16'h0000);
    for (int t = 1; t < 15; t++) begin
      applyStimulus((t == 1 || t == 7 || t == 8) ? 8'h20 : 8'h00,
                    (t == 12) ? 8'h20 : 8'h00, 1'b0);
    end

    // Starvation: seats 1 and 3 eat staggered so seat 2 is always blocked.
    test_id = 5;
    resetDut();
    applyStimulus(8'h02, 8'h00, 1'b0);
    expectAt(2, K_GRANT, 16'h0002);
    expectAt(5, K_GRANT, 16'h000A);
    expectAt(18, K_STARVE, 16'h0000);
    expectAt(18, K_FR, 16'h0002);
    expectAt(19, K_STARVE, 16'h0004);
    expectAt(19, K_GRANT, 16'h0008);
    expectAt(21, K_GRANT, 16'h0000);
    expectAt(21, K_FR, 16'h0008);
    expectAt(21, K_STARVE, 16'h0004);
    expectAt(22, K_GRANT, 16'h0004);
    expectAt(22, K_STARVE, 16'h0000);
    expectAt(23, K_GRANT, 16'h0000);
    for (int t = 1; t < 24; t++) begin
      r = (t < 2) ? 8'h02 : (t == 2) ? 8'h06 : (t < 22) ? 8'h0E : 8'h00;
      applyStimulus(r, (t == 22) ? 8'h04 : 8'h00, 1'b0);
    end

    // Reset while seats 0, 2, 4 eat and seats 1, 3 wait.
    test_id = 6;
    resetDut();
    applyStimulus(8'h15, 8'h00, 1'b0);
    expectAt(2, K_GRANT, 16'h0015);
    expectAt(2, K_STATE, 16'h0266);
    expectAt(2, K_RR, 16'h0001);
    expectAt(3, K_GRANT, 16'h0000);
    expectAt(3, K_STATE, 16'h0000);
    expectAt(3, K_RR, 16'h0000);
    expectAt(3, K_FR, 16'h0000);
    expectAt(4, K_FR, 16'h0000);
    expectAt(4, K_GRANT, 16'h0000);
    applyStimulus(8'h1F, 8'h00, 1'b0);
    applyStimulus(8'h1F, 8'h00, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    foreach (sb[i]) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL test%0d %s cycle %0d: never compared, expected %h",
               sb[i].tag, kindName(sb[i].kind), sb[i].at, sb[i].value);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dining_waiter.md
Name: dining_waiter

Overview:
- Central fork arbiter ("waiter") for a ring of N_SEATS philosophers; the responder side of the hungry/eat protocol.
- Each philosopher raises a request when hungry. The waiter grants eating permission so that ring-adjacent seats never eat together.
- Grants rotate round-robin; starving seats get priority; overlong meals are forcibly ended.
- Its seat-state output uses the shared t_state encoding, so the existing starvation and Buechi-style monitors attach unchanged.

Parameters:
- N_SEATS, 8, number of seats in the ring (>=3); seat i neighbours (i-1) mod N and (i+1) mod N.
- MAX_EAT, 4, maximum consecutive cycles a seat may hold a grant.
- STARVE_LIMIT, 16, wait cycles after which a waiting seat becomes starving.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- req  in  N_SEATS  per-seat hungry request (level).
- done  in  N_SEATS  per-seat release request (level, honoured only while eating).
- grant  out  N_SEATS  per-seat eat permission; registered; held until release.
- force_release  out  N_SEATS  one-cycle pulse when a seat loses its grant by MAX_EAT timeout.
- starve  out  N_SEATS  level; seat waiting with wait_cnt == STARVE_LIMIT.
- seat_state  out  2*N_SEATS  per-seat t_state view: IDLE=THINKING, WAIT=HUNGRY, EAT=EATING. READING is never produced.
- rr_ptr  out  clog2(N_SEATS)  current round-robin start seat.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- On reset, every seat goes to IDLE.
  - grant=0, force_release=0, starve=0, seat_state=THINKING for all seats, rr_ptr=0.
  - All wait_cnt and eat_cnt are cleared.
  - Reset mid-meal drops grants on the next edge with no force_release pulse.
- Per-seat FSM, all transitions on the clock edge:
  - IDLE: req=1 goes to WAIT; wait_cnt=0.
  - WAIT, req=0: withdraw to IDLE; no grant is issued.
  - WAIT, req=1 and selected by arbitration: go to EAT; eat_cnt=1.
  - WAIT, otherwise: stay in WAIT; wait_cnt increments, saturating at STARVE_LIMIT.
  - EAT, done=1: go to IDLE. req in that same cycle is ignored, so re-request takes effect the following cycle.
  - EAT, done=0 and eat_cnt==MAX_EAT: go to IDLE; force_release[i]=1 for exactly the next cycle.
  - EAT, otherwise: eat_cnt increments.
  - done and timeout in the same cycle count as a normal release, with no pulse.
- Arbitration is combinational on current registered state; grants are registered.
  - Eligibility: a seat in WAIT with req=1 whose two neighbours are not currently EAT.
  - Pass 1: scan starving eligible seats in order rr_ptr, rr_ptr+1, … (mod N). Select a seat if neither neighbour was already selected in this scan.
  - Pass 2: same scan over non-starving eligible seats. Additionally exclude any seat adjacent to a starving WAIT seat, even an unselected one.
  - Multiple non-adjacent grants per cycle are allowed.
- rr_ptr update: if any seat is selected, rr_ptr <= (first selected seat in pass-2 order, else pass-1 order) + 1 mod N. Otherwise it is unchanged.
- Latency:
  - req rising in cycle t gives seat_state=HUNGRY at t+1 and grant at t+2 at the earliest.
  - done in cycle k clears grant at k+1; a blocked neighbour can be granted at k+2.
- Invariant, checked by assertion: never grant[i] && grant[(i+1) mod N], including the wrap pair N-1/0.
- Counter widths:
  - wait_cnt is clog2(STARVE_LIMIT+1) bits.
  - eat_cnt is clog2(MAX_EAT+1) bits.
  - No wrap-around; saturation only.

Decomposition:
- Shared package: t_state enum (THINKING=0, HUNGRY=1, EATING=2, READING=3), seat FSM enum (IDLE, WAIT, EAT), and clog2 helper.
- One sub-module, waiter_seat, instantiated N_SEATS times. It holds the per-seat FSM, wait_cnt, eat_cnt, starve and force_release generation, and takes a 1-bit select input.
- The ring arbiter and rr_ptr stay in dining_waiter.

Test Plan (N_SEATS=8, MAX_EAT=4, STARVE_LIMIT=16):
- Single request: reset, then req[3]=1 at cycle 0 -> seat_state[3]=HUNGRY at cycle 1, grant[3]=1 at cycle 2, rr_ptr=4 at cycle 2.
- Adjacent contention: rr_ptr=0, req[2]=req[3]=1 together -> only grant[2]=1, rr_ptr=3. done[2] at cycle k -> grant[2]=0 at k+1, grant[3]=1 at k+2.
- Ring wrap: rr_ptr=7, req[7]=req[0]=1 together -> grant[7]=1 and grant[0]=0. With req[1]=1 also high, grant[1]=1 at the same cycle as grant[7].
- Timeout: seat 5 granted, done held 0 -> grant[5] high 4 cycles, then grant[5]=0 and force_release[5]=1 for one cycle. done[5]=1 on the 4th cycle -> no pulse.
- Starvation priority: keep seats 1 and 3 alternately eating so seat 2 waits -> starve[2]=1 after 16 wait cycles. Seats 1 and 3 are then not re-granted, and grant[2]=1 immediately after both release.
- Reset mid-operation: grants on seats 0, 2, 4 with seats 1, 3 waiting; assert reset one cycle -> next cycle all grant=0, all seat_state=THINKING, rr_ptr=0, no force_release pulse.
